// File: rtl/ibm.sv
// Input buffer manager for one egress port: takes a free buffer ID per packet,
// writes beats into packet RAM at {ID,beat}, and emits a descriptor on a kept
// tail. IDs come back either from the output scheduler (release) or internally
// when a packet is dropped (return).
module ibm #(
  parameter int ID_NUM = 16,
  parameter int ID_W   = 4,
  parameter int BEAT_W = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [133:0]           in_ibm_data,
  input  logic                   in_ibm_data_wr,
  input  logic                   in_ibm_valid,
  input  logic                   in_ibm_valid_wr,
  input  logic [23:0]            in_ibm_tsn_md,
  input  logic                   in_ibm_tsn_md_wr,
  output logic [ID_W:0]          bufm_ID_count,
  output logic                   buf_wr_en,
  output logic [ID_W+BEAT_W-1:0] buf_wr_addr,
  output logic [133:0]           buf_wr_data,
  output logic [23:0]            out_desc_md,
  output logic [ID_W-1:0]        out_desc_id,
  output logic [7:0]             out_desc_len,
  output logic                   out_desc_wr,
  input  logic [ID_W-1:0]        in_free_id,
  input  logic                   in_free_id_wr,
  output logic [63:0]            ibm_pktin_cnt,
  output logic [63:0]            ibm_drop_cnt,
  output logic [15:0]            ibm_err_cnt
);

  typedef enum logic [1:0] {IDLE, WR, DISC} state_t;

  localparam logic [ID_NUM-1:0] ONE = {{(ID_NUM-1){1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [ID_NUM-1:0]   bitmap, bitmap_nxt, alloc_mask, ret_mask, rel_mask;
  logic [ID_W-1:0]     cur_id, cur_id_nxt, low_id, wr_id;
  logic [BEAT_W-1:0]   beat, beat_nxt, wr_beat;
  logic [23:0]         md_q, md_nxt;
  logic [ID_W:0]       cnt_nxt;
  logic                any_free, is_head, is_body, is_tail, keep;
  logic                take_head, wr_go, desc_go, pkt_inc, rel_bad;
  logic [1:0]          drop_inc, err_inc;
  logic [16:0]         err_sum;

  assign is_head  = in_ibm_data_wr && (in_ibm_data[133:132] == 2'b01);
  assign is_body  = in_ibm_data_wr && (in_ibm_data[133:132] == 2'b11);
  assign is_tail  = in_ibm_data_wr && (in_ibm_data[133:132] == 2'b10);
  assign keep     = in_ibm_valid_wr && in_ibm_valid;
  assign any_free = |bitmap;

  // Priority pick of the lowest-index free ID from the registered bitmap.
  always_comb begin
    low_id = '0;
    for (int i = ID_NUM - 1; i >= 0; i--)
      if (bitmap[i]) low_id = i[ID_W-1:0];
  end

  // Releasing an ID that is already free is a protocol error and is ignored.
  always_comb begin
    rel_mask = '0;
    rel_bad  = 1'b0;
    if (in_free_id_wr) begin
      if (bitmap[in_free_id]) rel_bad  = 1'b1;
      else                    rel_mask = ONE << in_free_id;
    end
  end

  // Next-state, RAM write, descriptor and counter-increment decode.
  always_comb begin
    state_nxt  = state;
    cur_id_nxt = cur_id;
    beat_nxt   = beat;
    md_nxt     = md_q;
    alloc_mask = '0;
    ret_mask   = '0;
    wr_go      = 1'b0;
    wr_id      = cur_id;
    wr_beat    = beat;
    desc_go    = 1'b0;
    drop_inc   = 2'd0;
    err_inc    = 2'd0;
    pkt_inc    = 1'b0;
    take_head  = 1'b0;
    if (in_ibm_data_wr) begin
      case (state)
        IDLE: begin
          if (is_head) take_head = 1'b1;
          else         err_inc   = 2'd1;
        end
        WR: begin
          if (is_head) begin
            // Missing tail: give back the old ID, restart with the new head.
            ret_mask  = ONE << cur_id;
            drop_inc  = 2'd1;
            err_inc   = 2'd1;
            take_head = 1'b1;
          end else if (is_body || is_tail) begin
            if (&beat) begin
              // Overlength: the buffer is full, discard the rest of the packet.
              ret_mask  = ONE << cur_id;
              drop_inc  = 2'd1;
              state_nxt = is_tail ? IDLE : DISC;
            end else begin
              wr_go    = 1'b1;
              wr_beat  = beat + 1'b1;
              beat_nxt = beat + 1'b1;
              if (is_tail) begin
                state_nxt = IDLE;
                if (keep) desc_go = 1'b1;
                else begin
                  ret_mask = ONE << cur_id;
                  drop_inc = 2'd1;
                end
              end
            end
          end
        end
        DISC: begin
          if (is_head) begin
            err_inc   = 2'd1;
            take_head = 1'b1;
          end else if (is_tail) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    // An ID returned this cycle is not reused by a head in the same cycle.
    if (take_head) begin
      pkt_inc = 1'b1;
      md_nxt  = in_ibm_tsn_md_wr ? in_ibm_tsn_md : '0;
      if (any_free) begin
        alloc_mask = ONE << low_id;
        cur_id_nxt = low_id;
        beat_nxt   = '0;
        wr_go      = 1'b1;
        wr_id      = low_id;
        wr_beat    = '0;
        state_nxt  = WR;
      end else begin
        drop_inc  = drop_inc + 2'd1;
        state_nxt = DISC;
      end
    end
  end

  // Bitmap sets and clears land together; count tracks the new bitmap.
  always_comb begin
    bitmap_nxt = (bitmap | rel_mask | ret_mask) & ~alloc_mask;
    cnt_nxt    = '0;
    for (int i = 0; i < ID_NUM; i++)
      cnt_nxt = cnt_nxt + (ID_W+1)'(bitmap_nxt[i]);
    err_sum = {1'b0, ibm_err_cnt} + 17'(err_inc) + 17'(rel_bad);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Buffer bookkeeping, registered RAM/descriptor outputs and statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bitmap        <= '1;
      bufm_ID_count <= (ID_W+1)'(ID_NUM);
      cur_id        <= '0;
      beat          <= '0;
      md_q          <= '0;
      buf_wr_en     <= 1'b0;
      buf_wr_addr   <= '0;
      buf_wr_data   <= '0;
      out_desc_md   <= '0;
      out_desc_id   <= '0;
      out_desc_len  <= '0;
      out_desc_wr   <= 1'b0;
      ibm_pktin_cnt <= '0;
      ibm_drop_cnt  <= '0;
      ibm_err_cnt   <= '0;
    end else begin
      bitmap        <= bitmap_nxt;
      bufm_ID_count <= cnt_nxt;
      cur_id        <= cur_id_nxt;
      beat          <= beat_nxt;
      md_q          <= md_nxt;
      buf_wr_en     <= wr_go;
      if (wr_go) begin
        buf_wr_addr <= {wr_id, wr_beat};
        buf_wr_data <= in_ibm_data;
      end
      out_desc_wr <= desc_go;
      if (desc_go) begin
        out_desc_md  <= md_q;
        out_desc_id  <= cur_id;
        out_desc_len <= 8'(beat) + 8'd2;
      end
      ibm_pktin_cnt <= ibm_pktin_cnt + 64'(pkt_inc);
      ibm_drop_cnt  <= ibm_drop_cnt + 64'(drop_inc);
      ibm_err_cnt   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule

// File: tb/tb_ibm.sv
// Bench for ibm: a packet-level model (free-ID array, expected write and
// descriptor queues) plus a table of hand-computed packet outcomes and
// directed sequences for the multi-cycle corner cases.
module tb_ibm;
  localparam int ID_NUM = 16;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic [133:0] in_ibm_data = '0;
  logic         in_ibm_data_wr = 1'b0, in_ibm_valid = 1'b0, in_ibm_valid_wr = 1'b0;
  logic [23:0]  in_ibm_tsn_md = '0;
  logic         in_ibm_tsn_md_wr = 1'b0;
  logic [4:0]   bufm_ID_count;
  logic         buf_wr_en;
  logic [10:0]  buf_wr_addr;
  logic [133:0] buf_wr_data;
  logic [23:0]  out_desc_md;
  logic [3:0]   out_desc_id;
  logic [7:0]   out_desc_len;
  logic         out_desc_wr;
  logic [3:0]   in_free_id = '0;
  logic         in_free_id_wr = 1'b0;
  logic [63:0]  ibm_pktin_cnt, ibm_drop_cnt;
  logic [15:0]  ibm_err_cnt;

  always #5 clk = ~clk;

  ibm dut (
    .clk(clk), .rst_n(rst_n),
    .in_ibm_data(in_ibm_data), .in_ibm_data_wr(in_ibm_data_wr),
    .in_ibm_valid(in_ibm_valid), .in_ibm_valid_wr(in_ibm_valid_wr),
    .in_ibm_tsn_md(in_ibm_tsn_md), .in_ibm_tsn_md_wr(in_ibm_tsn_md_wr),
    .bufm_ID_count(bufm_ID_count),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .out_desc_md(out_desc_md), .out_desc_id(out_desc_id), .out_desc_len(out_desc_len),
    .out_desc_wr(out_desc_wr),
    .in_free_id(in_free_id), .in_free_id_wr(in_free_id_wr),
    .ibm_pktin_cnt(ibm_pktin_cnt), .ibm_drop_cnt(ibm_drop_cnt), .ibm_err_cnt(ibm_err_cnt)
  );

  typedef struct packed {logic [10:0] addr; logic [133:0] data;} wr_t;
  typedef struct packed {logic [23:0] md; logic [3:0] id; logic [7:0] len;} desc_t;
  typedef struct {int n; logic [23:0] md; logic keep; int exp_id; int exp_len; int exp_cnt;} vec_t;

  int      errors = 0, checks = 0;
  wr_t     wr_q[$];
  desc_t   desc_q[$];
  desc_t   last_desc;
  int      n_desc = 0;
  wr_t     mon_w;
  desc_t   mon_d;
  bit      mfree[ID_NUM];
  longint  m_pktin, m_drop, m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: every RAM write and descriptor must match the model's queue head.
  always @(negedge clk) begin
    if (buf_wr_en === 1'b1) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %0h expected no write", buf_wr_addr);
      end else begin
        mon_w = wr_q.pop_front();
        if (buf_wr_addr !== mon_w.addr || buf_wr_data !== mon_w.data) begin
          errors++;
          $display("FAIL wr_beat: got addr %0h data %0h expected addr %0h data %0h",
                   buf_wr_addr, buf_wr_data, mon_w.addr, mon_w.data);
        end
      end
    end
    if (out_desc_wr === 1'b1) begin
      last_desc = {out_desc_md, out_desc_id, out_desc_len};
      n_desc++;
      checks++;
      if (desc_q.size() == 0) begin
        errors++;
        $display("FAIL desc_unexpected: got %0h expected no descriptor", last_desc);
      end else begin
        mon_d = desc_q.pop_front();
        if (last_desc !== mon_d) begin
          errors++;
          $display("FAIL desc: got %0h expected %0h", last_desc, mon_d);
        end
      end
    end
  end

  function automatic int m_lowest();
    for (int i = 0; i < ID_NUM; i++) if (mfree[i]) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < ID_NUM; i++) c += int'(mfree[i]);
    return c;
  endfunction

  function automatic void m_release(input int id);
    if (mfree[id]) m_err++;
    else           mfree[id] = 1'b1;
  endfunction

  function automatic logic [133:0] rnd_beat(input logic [1:0] typ);
    return {typ, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic beat(input logic [133:0] d, input logic [23:0] md, input logic keep,
                      input logic rel_en, input logic [3:0] rel_id);
    in_ibm_data      = d;
    in_ibm_data_wr   = 1'b1;
    in_ibm_tsn_md_wr = (d[133:132] == 2'b01);
    in_ibm_tsn_md    = md;
    in_ibm_valid_wr  = (d[133:132] == 2'b10);
    in_ibm_valid     = keep;
    in_free_id_wr    = rel_en;
    in_free_id       = rel_id;
    @(posedge clk); #1;
    in_ibm_data_wr = 1'b0; in_ibm_tsn_md_wr = 1'b0; in_ibm_valid_wr = 1'b0; in_free_id_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic release_id(input int id);
    m_release(id);
    in_free_id = 4'(id); in_free_id_wr = 1'b1;
    @(posedge clk); #1;
    in_free_id_wr = 1'b0;
  endtask

  task automatic release_all();
    for (int i = 0; i < ID_NUM; i++) if (!mfree[i]) release_id(i);
  endtask

  // Whole packet: the model decides ID, writes and fate before the beats go in.
  task automatic send_pkt(input int n, input logic [23:0] md, input logic keep,
                          input logic rel_en, input logic [3:0] rel_id);
    int id;
    logic [133:0] d;
    id = m_lowest();
    m_pktin++;
    if (id < 0) m_drop++;
    else        mfree[id] = 1'b0;
    for (int b = 0; b < n; b++) begin
      d = rnd_beat((b == 0) ? 2'b01 : (b == n - 1) ? 2'b10 : 2'b11);
      if (id >= 0 && b < 128) wr_q.push_back({4'(id), 7'(b), d});
      beat(d, md, keep, rel_en && (b == n - 1), rel_id);
    end
    if (rel_en) m_release(int'(rel_id));
    if (id >= 0) begin
      if (n > 128 || !keep) begin m_drop++; mfree[id] = 1'b1; end
      else desc_q.push_back({md, 4'(id), 8'(n)});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < ID_NUM; i++) mfree[i] = 1'b1;
    m_pktin = 0; m_drop = 0; m_err = 0;
    wr_q.delete(); desc_q.delete();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_count"}, 64'(bufm_ID_count), 64'(m_count()));
    chk({tag, "_pktin"}, ibm_pktin_cnt, m_pktin);
    chk({tag, "_drop"},  ibm_drop_cnt,  m_drop);
    chk({tag, "_err"},   64'(ibm_err_cnt), m_err);
  endtask

  initial begin
    vec_t tbl[5];
    logic [133:0] d;
    int nd;
    tbl[0] = '{3,   24'hABCDEF, 1'b1, 0, 3,   15};
    tbl[1] = '{2,   24'h111111, 1'b0, 1, 0,   15};
    tbl[2] = '{4,   24'h222222, 1'b1, 1, 4,   14};
    tbl[3] = '{128, 24'h333333, 1'b1, 2, 128, 13};
    tbl[4] = '{2,   24'h444444, 1'b1, 3, 2,   12};

    do_reset();
    chk("rst_count", 64'(bufm_ID_count), 64'd16);
    chk("rst_wr_en", 64'(buf_wr_en), 64'd0);
    chk("rst_wr_addr", 64'(buf_wr_addr), 64'd0);
    chk("rst_desc_wr", 64'(out_desc_wr), 64'd0);
    chk("rst_desc_len", 64'(out_desc_len), 64'd0);
    chk("rst_pktin", ibm_pktin_cnt, 64'd0);
    chk("rst_drop", ibm_drop_cnt, 64'd0);
    chk("rst_err", 64'(ibm_err_cnt), 64'd0);

    // Table of packets from a fresh reset with hand-derived ID/len/free count.
    foreach (tbl[i]) begin
      nd = n_desc;
      send_pkt(tbl[i].n, tbl[i].md, tbl[i].keep, 1'b0, 4'd0);
      chk($sformatf("tbl%0d_count", i), 64'(bufm_ID_count), 64'(tbl[i].exp_cnt));
      idle(1);
      chk($sformatf("tbl%0d_ndesc", i), 64'(n_desc), 64'(nd + int'(tbl[i].keep)));
      if (tbl[i].keep)
        chk($sformatf("tbl%0d_desc", i), 64'(last_desc),
            64'({tbl[i].md, 4'(tbl[i].exp_id), 8'(tbl[i].exp_len)}));
    end
    chk("tbl_drop", ibm_drop_cnt, 64'd1);

    // Exhaust all IDs, then a head with nothing free is dropped without writes.
    for (int i = 0; i < 12; i++) send_pkt(2, 24'($urandom), 1'b1, 1'b0, 4'd0);
    chk("full_count", 64'(bufm_ID_count), 64'd0);
    send_pkt(3, 24'h777777, 1'b1, 1'b0, 4'd0);
    chk("full_drop", ibm_drop_cnt, 64'd2);
    chk("full_count2", 64'(bufm_ID_count), 64'd0);
    release_id(5);
    chk("rel5_count", 64'(bufm_ID_count), 64'd1);
    send_pkt(2, 24'h555555, 1'b1, 1'b0, 4'd0);
    idle(1);
    chk("rel5_desc", 64'(last_desc), 64'({24'h555555, 4'd5, 8'd2}));
    chk_model("t2");

    // Overlength: only beats 0..127 land, ID comes back and is reused.
    release_all();
    chk("free_all", 64'(bufm_ID_count), 64'd16);
    send_pkt(129, 24'h999999, 1'b1, 1'b0, 4'd0);
    chk("ovl_count", 64'(bufm_ID_count), 64'd16);
    chk("ovl_drop", ibm_drop_cnt, 64'd3);
    send_pkt(2, 24'h121212, 1'b1, 1'b0, 4'd0);
    idle(1);
    chk("ovl_reuse", 64'(last_desc), 64'({24'h121212, 4'd0, 8'd2}));
    release_all();

    // Release of 3 coincides with a valid=0 tail returning 7.
    for (int i = 0; i < 8; i++) send_pkt(2, 24'($urandom), 1'b1, 1'b0, 4'd0);
    release_id(7);
    chk("pre_dual_count", 64'(bufm_ID_count), 64'd9);
    send_pkt(3, 24'h343434, 1'b0, 1'b1, 4'd3);
    chk("dual_count", 64'(bufm_ID_count), 64'd10);
    chk("dual_err0", 64'(ibm_err_cnt), 64'd0);
    release_id(3);
    chk("dbl_free_err", 64'(ibm_err_cnt), 64'd1);
    chk("dbl_free_count", 64'(bufm_ID_count), 64'd10);
    release_all();
    chk_model("t5");

    // Head, body, head: first ID returned, second packet completes on ID1.
    d = rnd_beat(2'b01); wr_q.push_back({4'd0, 7'd0, d}); beat(d, 24'hAAAA01, 1'b0, 1'b0, 4'd0);
    d = rnd_beat(2'b11); wr_q.push_back({4'd0, 7'd1, d}); beat(d, 24'h0, 1'b0, 1'b0, 4'd0);
    d = rnd_beat(2'b01); wr_q.push_back({4'd1, 7'd0, d}); beat(d, 24'hBBBB02, 1'b0, 1'b0, 4'd0);
    d = rnd_beat(2'b11); wr_q.push_back({4'd1, 7'd1, d}); beat(d, 24'h0, 1'b0, 1'b0, 4'd0);
    d = rnd_beat(2'b10); wr_q.push_back({4'd1, 7'd2, d}); beat(d, 24'h0, 1'b1, 1'b0, 4'd0);
    desc_q.push_back({24'hBBBB02, 4'd1, 8'd3});
    m_pktin += 2; m_drop++; m_err++; mfree[1] = 1'b0;
    idle(1);
    chk("mt_desc", 64'(last_desc), 64'({24'hBBBB02, 4'd1, 8'd3}));
    chk("mt_err", 64'(ibm_err_cnt), 64'd2);
    chk("mt_count", 64'(bufm_ID_count), 64'd15);
    // Stray body beat while idle is an error with no RAM write.
    d = rnd_beat(2'b11); beat(d, 24'h0, 1'b0, 1'b0, 4'd0);
    m_err++;
    idle(1);
    chk("stray_err", 64'(ibm_err_cnt), 64'd3);
    chk_model("t6");

    // Random traffic against the model.
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 3) == 0) release_id($urandom_range(0, ID_NUM - 1));
      else send_pkt($urandom_range(2, 10), 24'($urandom), $urandom_range(0, 3) != 0, 1'b0, 4'd0);
      chk($sformatf("rnd%0d_count", it), 64'(bufm_ID_count), 64'(m_count()));
      if (it % 20 == 19) chk_model("rnd");
    end
    idle(2);
    chk("q_wr_left", 64'(wr_q.size()), 64'd0);
    chk("q_desc_left", 64'(desc_q.size()), 64'd0);

    // Reset in the middle of a packet: nothing more emitted, all IDs free.
    release_id(0);
    nd = n_desc;
    d = rnd_beat(2'b01); wr_q.push_back({4'(m_lowest()), 7'd0, d}); beat(d, 24'hCAFE00, 1'b0, 1'b0, 4'd0);
    d = rnd_beat(2'b11); wr_q.push_back({4'(m_lowest()), 7'd1, d}); beat(d, 24'h0, 1'b0, 1'b0, 4'd0);
    do_reset();
    idle(2);
    chk("mid_rst_count", 64'(bufm_ID_count), 64'd16);
    chk("mid_rst_ndesc", 64'(n_desc), 64'(nd));
    chk("mid_rst_wr_en", 64'(buf_wr_en), 64'd0);
    chk_model("mid_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
